// File: rtl/mtd_framer.sv
// Frames FIFO words as: header, FRAME_LEN payload words, optional checksum word.
// Latency: header is presented one cycle after FIFO non-empty; each payload word takes 3 cycles (fetch, load, present).
// Backpressure: outputs are held while OUT_VALID=1 and OUT_READY=0; no FIFO read is issued until the current word is accepted.
// Optional feature macro: MTD_FRAMER_CHKSUM_EN appends a 16-bit modular checksum word carrying EOF.
module mtd_framer #(
    parameter int          FRAME_LEN = 8,
    parameter logic [15:0] HDR_WORD  = 16'hA55A
) (
    input  logic        RCLK,
    input  logic        RST,
    input  logic [15:0] FIFO_Q,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RE,
    output logic [15:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_SOF,
    output logic        OUT_EOF,
    output logic [15:0] FRAME_CNT,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_PAY   = 3'd4
`ifdef MTD_FRAMER_CHKSUM_EN
        , S_SUM = 3'd5
`endif
    } state_t;

    localparam logic [7:0] IDX_LAST = 8'(FRAME_LEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_idx;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic [15:0] r_frame_cnt;
    logic        w_xfer;
    logic        w_last;
    logic        w_re;
`ifdef MTD_FRAMER_CHKSUM_EN
    logic [15:0] r_chk;
`endif

    assign w_xfer = r_valid & OUT_READY;
    assign w_last = (r_idx == IDX_LAST);

    // State register
    always_ff @(posedge RCLK) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!FIFO_EMPTY) w_next = S_HDR;
            S_HDR:   if (w_xfer)      w_next = S_FETCH;
            S_FETCH: if (w_re)        w_next = S_LOAD;
            S_LOAD:                   w_next = S_PAY;
            S_PAY: begin
                if (w_xfer) begin
                    if (!w_last)      w_next = S_FETCH;
`ifdef MTD_FRAMER_CHKSUM_EN
                    else              w_next = S_SUM;
`else
                    else              w_next = S_IDLE;
`endif
                end
            end
`ifdef MTD_FRAMER_CHKSUM_EN
            S_SUM:   if (w_xfer)      w_next = S_IDLE;
`endif
            default:                  w_next = S_IDLE;
        endcase
    end

    // Output decode: FIFO read only when fetching, data available and out of reset
    always_comb begin
        w_re = (r_state == S_FETCH) && !FIFO_EMPTY && RST;
        BUSY = (r_state != S_IDLE);
    end

    // Output word, flags, index, checksum and frame counter
    always_ff @(posedge RCLK) begin
        if (!RST) begin
            r_data      <= 16'h0000;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_idx       <= 8'd0;
            r_frame_cnt <= 16'h0000;
`ifdef MTD_FRAMER_CHKSUM_EN
            r_chk       <= 16'h0000;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= 8'd0;
`ifdef MTD_FRAMER_CHKSUM_EN
                    r_chk <= 16'h0000;
`endif
                    if (!FIFO_EMPTY) begin
                        r_data  <= HDR_WORD;
                        r_sof   <= 1'b1;
                        r_eof   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_sof   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_data  <= FIFO_Q;
                    r_valid <= 1'b1;
`ifdef MTD_FRAMER_CHKSUM_EN
                    r_chk   <= r_chk + FIFO_Q;
                    r_eof   <= 1'b0;
`else
                    r_eof   <= w_last;
`endif
                end
                S_PAY: begin
                    if (w_xfer) begin
                        if (!w_last) begin
                            r_idx   <= r_idx + 8'd1;
                            r_valid <= 1'b0;
                        end else begin
`ifdef MTD_FRAMER_CHKSUM_EN
                            // checksum already includes the last word, captured in LOAD
                            r_data  <= r_chk;
                            r_eof   <= 1'b1;
`else
                            r_valid     <= 1'b0;
                            r_eof       <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
                        end
                    end
                end
`ifdef MTD_FRAMER_CHKSUM_EN
                S_SUM: begin
                    if (w_xfer) begin
                        r_valid     <= 1'b0;
                        r_eof       <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign FIFO_RE   = w_re;
    assign OUT_DATA  = r_data;
    assign OUT_VALID = r_valid;
    assign OUT_SOF   = r_sof;
    assign OUT_EOF   = r_eof;
    assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_mtd_framer.sv
// Directed bench for mtd_framer: frame stream, timing, backpressure, underflow, checksum wrap, mid-frame reset.
// Uses a small FIFO model sharing RCLK/RST with the framer; read data appears one cycle after FIFO_RE.
// Expected streams are built from payload tables; works with or without MTD_FRAMER_CHKSUM_EN.
module tb_mtd_framer;

`ifdef MTD_FRAMER_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NW = 9 + CHK;

    logic        RCLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] FIFO_Q = 16'h0000;
    logic        FIFO_EMPTY;
    logic        FIFO_RE;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        OUT_SOF;
    logic        OUT_EOF;
    logic [15:0] FRAME_CNT;
    logic        BUSY;

    mtd_framer dut (
        .RCLK(RCLK), .RST(RST), .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RE(FIFO_RE), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF),
        .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
    );

    always #5 RCLK = ~RCLK;

    // FIFO model
    logic [15:0] mem [0:255];
    logic [7:0]  rd = 8'd0;
    logic [7:0]  wr = 8'd0;
    assign FIFO_EMPTY = (rd == wr);
    always @(posedge RCLK) begin
        if (!RST) rd <= wr;
        else if (FIFO_RE) begin
            FIFO_Q <= mem[rd];
            rd     <= rd + 8'd1;
        end
    end

    int cyc = 0;
    always @(posedge RCLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int re_bad = 0;
    // FIFO_RE must never fire while empty, in reset, or while a word is outstanding
    always @(negedge RCLK) if (FIFO_RE && (FIFO_EMPTY || !RST || OUT_VALID)) re_bad++;

    typedef struct {
        logic [15:0] in_word;
        logic [15:0] exp_dat;
        logic        exp_sof;
        logic        exp_eof;
    } vec_t;

    vec_t        tbl [0:9];
    logic [15:0] pay [0:7];
    int          got_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr] = v;
        wr = wr + 8'd1;
    endtask

    task automatic build_tbl();
        logic [15:0] s;
        s = 16'h0000;
        tbl[0] = '{16'h0000, 16'hA55A, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            s = s + pay[i];
            tbl[i+1] = '{pay[i], pay[i], 1'b0, (i == 7) && (CHK == 0)};
        end
        tbl[9] = '{16'h0000, s, 1'b0, 1'b1};
    endtask

    // Wait (bounded) for a transfer and capture the word; skip_wait captures at the current negedge
    task automatic get_word(input bit skip_wait, output logic [15:0] d, output logic s, output logic e);
        int n;
        n = 0; d = 16'h0; s = 1'b0; e = 1'b0;
        if (!skip_wait) @(negedge RCLK);
        while (!(OUT_VALID && OUT_READY) && n < 300) begin
            @(negedge RCLK);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL xfer_timeout actual=no_transfer required=transfer");
        end else begin
            d = OUT_DATA; s = OUT_SOF; e = OUT_EOF; got_cyc = cyc;
            @(posedge RCLK);
        end
    endtask

    task automatic receive_frame(input bit do_push, input int stall_at, input int starve_after,
                                 input int abort_at, output int hdr_cyc);
        logic [15:0] d;
        logic        s, e;
        bit          skip;
        int          n;
        hdr_cyc = 0;
        build_tbl();
        if (do_push) begin
            @(negedge RCLK);
            for (int i = 0; i < 8; i++)
                if (starve_after < 0 || i < starve_after) push(tbl[i+1].in_word);
        end
        for (int k = 0; k < NW; k++) begin
            if (k == abort_at) return;
            skip = 1'b0;
            if (starve_after >= 0 && k == starve_after + 1) begin
                repeat (8) begin
                    @(negedge RCLK);
                    chk("starve_re", FIFO_RE, 0);
                    chk("starve_busy", BUSY, 1);
                    chk("starve_valid", OUT_VALID, 0);
                end
                for (int i = starve_after; i < 8; i++) push(tbl[i+1].in_word);
            end
            if (k == stall_at) begin
                n = 0;
                @(negedge RCLK);
                while (!OUT_VALID && n < 100) begin @(negedge RCLK); n++; end
                OUT_READY = 1'b0;
                repeat (5) begin
                    @(negedge RCLK);
                    chk("stall_dat", OUT_DATA, tbl[k].exp_dat);
                    chk("stall_vld", OUT_VALID, 1);
                    chk("stall_re", FIFO_RE, 0);
                end
                OUT_READY = 1'b1;
                skip = 1'b1;
            end
            get_word(skip, d, s, e);
            if (k == 0) hdr_cyc = got_cyc;
            chk($sformatf("dat[%0d]", k), d, tbl[k].exp_dat);
            chk($sformatf("sof[%0d]", k), s, tbl[k].exp_sof);
            chk($sformatf("eof[%0d]", k), e, tbl[k].exp_eof);
        end
    endtask

    initial begin
        int h1, h2, n;
        // reset state
        RST = 1'b0;
        repeat (2) @(posedge RCLK);
        @(negedge RCLK);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_re", FIFO_RE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cnt", FRAME_CNT, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_sof", OUT_SOF, 0);
        chk("rst_eof", OUT_EOF, 0);
        RST = 1'b1;

        // two back-to-back nominal frames from a full FIFO: check period
        for (int i = 0; i < 8; i++) pay[i] = 16'(i + 1);
        for (int f = 0; f < 2; f++) for (int i = 0; i < 8; i++) push(pay[i]);
        receive_frame(1'b0, -1, -1, -1, h1);
        receive_frame(1'b0, -1, -1, -1, h2);
        chk("hdr_period", h2 - h1, 3 * 8 + 2 + CHK);
        @(negedge RCLK);
        chk("cnt_after_2", FRAME_CNT, 2);

        // backpressure on word 0003
        receive_frame(1'b1, 3, -1, -1, h1);
        @(negedge RCLK);
        chk("cnt_after_bp", FRAME_CNT, 3);

        // underflow after 3 payload words
        pay = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 16'h0080};
        receive_frame(1'b1, -1, 3, -1, h1);
        @(negedge RCLK);
        chk("cnt_after_uf", FRAME_CNT, 4);

        // checksum wrap
        for (int i = 0; i < 8; i++) pay[i] = 16'hFFFF;
        receive_frame(1'b1, -1, -1, -1, h1);
        if (CHK != 0) chk("wrap_sum", tbl[9].exp_dat, 16'hFFF8);
        @(negedge RCLK);
        chk("cnt_after_wrap", FRAME_CNT, 5);

        // reset while word 4 is presented
        for (int i = 0; i < 8; i++) pay[i] = 16'(i + 1);
        receive_frame(1'b1, -1, -1, 4, h1);
        n = 0;
        @(negedge RCLK);
        while (!OUT_VALID && n < 100) begin @(negedge RCLK); n++; end
        chk("abort_word", OUT_DATA, 16'h0004);
        RST = 1'b0;
        repeat (2) @(posedge RCLK);
        @(negedge RCLK);
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_re", FIFO_RE, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_cnt", FRAME_CNT, 0);
        RST = 1'b1;
        receive_frame(1'b1, -1, -1, -1, h1);
        @(negedge RCLK);
        chk("cnt_after_rst", FRAME_CNT, 1);
        chk("idle_busy", BUSY, 0);

        chk("fifo_re_legal", re_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mtd_framer.md
MTD_FRAMER -- requirements
Module: mtd_framer

Interface
REQ-001 The block SHALL have one clock RCLK; reset RST is synchronous and active-low.
REQ-002 Parameter FRAME_LEN SHALL default to 8 and set the payload words per frame (legal range 1..255).
REQ-003 Parameter HDR_WORD SHALL default to 16'hA55A and set the frame header word.
REQ-004 Port RCLK SHALL be an input, 1 bit wide: the read-side clock, shared with the upstream FIFO read port.
REQ-005 Port RST SHALL be an input, 1 bit wide: synchronous active-low reset.
REQ-006 Port FIFO_Q SHALL be an input, 16 bits wide: FIFO read data, valid one RCLK cycle after FIFO_RE.
REQ-007 Port FIFO_EMPTY SHALL be an input, 1 bit wide: FIFO empty flag.
REQ-008 Port FIFO_RE SHALL be an output, 1 bit wide: FIFO read enable.
REQ-009 Port OUT_DATA SHALL be an output, 16 bits wide: frame word.
REQ-010 Port OUT_VALID SHALL be an output, 1 bit wide: OUT_DATA, OUT_SOF and OUT_EOF are valid.
REQ-011 Port OUT_READY SHALL be an input, 1 bit wide: the consumer accepts the word.
REQ-012 Port OUT_SOF SHALL be an output, 1 bit wide: the current word is the header.
REQ-013 Port OUT_EOF SHALL be an output, 1 bit wide: the current word is the last word of the frame.
REQ-014 Port FRAME_CNT SHALL be an output, 16 bits wide: count of completed frames.
REQ-015 Port BUSY SHALL be an output, 1 bit wide: the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, HDR, FETCH, LOAD, PAY and SUM.
REQ-017 A transfer SHALL occur on an RCLK edge when OUT_VALID=1 and OUT_READY=1; while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_SOF and OUT_EOF SHALL be held stable.
REQ-018 IDLE: on FIFO_EMPTY=0, next state HDR; OUT_DATA<=HDR_WORD, OUT_SOF<=1, OUT_VALID<=1; word index and checksum cleared.
REQ-019 HDR: on transfer, next state FETCH; OUT_VALID<=0, OUT_SOF<=0.
REQ-020 FETCH: FIFO_RE SHALL be combinational, equal to (state==FETCH && FIFO_EMPTY==0); when it is 1, next state LOAD, otherwise remain in FETCH.
REQ-021 FIFO_RE SHALL never be 1 in any state other than FETCH, and SHALL never be 1 while FIFO_EMPTY=1.
REQ-022 LOAD: OUT_DATA<=FIFO_Q, OUT_VALID<=1, checksum<=checksum+FIFO_Q; next state PAY.
REQ-023 PAY: on transfer with index<FRAME_LEN-1, index increments and next state is FETCH; on transfer of the last word, see REQ-031/032.
REQ-024 SUM: OUT_DATA=checksum, OUT_EOF=1, OUT_VALID=1; on transfer, FRAME_CNT increments and next state is IDLE.
REQ-025 The checksum SHALL be the 16-bit sum of the payload words, modulo 2^16, with carries discarded.
REQ-026 FRAME_CNT SHALL wrap from 16'hFFFF to 0.
REQ-027 BUSY SHALL be 1 whenever the state is not IDLE.
REQ-028 Throughput with OUT_READY=1 and the FIFO never empty SHALL be one frame per 3*FRAME_LEN+3 cycles with checksum, or 3*FRAME_LEN+2 without.

Reset
REQ-029 With RST=0 at an RCLK edge, the FSM SHALL go to IDLE and OUT_VALID, OUT_SOF, OUT_EOF, OUT_DATA, FRAME_CNT, the checksum and the index SHALL all be 0; FIFO_RE SHALL be 0 while RST=0.
REQ-030 Reset mid-frame SHALL discard the partial frame, including any word already read from the FIFO; the next frame SHALL start with a header and a fresh checksum.

Configuration
REQ-031 With macro MTD_FRAMER_CHKSUM_EN defined: transfer of the last payload word SHALL go to SUM, and the last payload word SHALL carry OUT_EOF=0.
REQ-032 With MTD_FRAMER_CHKSUM_EN undefined: the SUM state and checksum register SHALL be absent; the last payload word SHALL carry OUT_EOF=1, and its transfer SHALL increment FRAME_CNT and go to IDLE.

Verification
REQ-033 Reset test: hold RST=0 for 2 cycles mid-stream -> OUT_VALID=0, FIFO_RE=0, BUSY=0, FRAME_CNT=0.
REQ-034 Nominal frame (macro defined): FIFO holds 1..8, OUT_READY=1 -> stream A55A(SOF), 0001..0008, 0024(EOF); FRAME_CNT=1; next header 27 cycles after the first.
REQ-035 Backpressure: OUT_READY=0 for 5 cycles while 0003 is presented -> OUT_DATA held at 0003, FIFO_RE=0 throughout, no word lost.
REQ-036 Underflow: FIFO empties after 3 payload words -> FSM stays in FETCH with FIFO_RE=0; the frame completes unchanged once the words arrive.
REQ-037 Wrap: payload 8 x FFFF -> checksum FFF8; FRAME_CNT preset via 65535 frames -> increments to 0000.
REQ-038 Macro undefined with 1..8 queued -> 0008 carries EOF, no checksum word; reset during word 4 then refill -> new frame starts with A55A.
